// File: rtl/sub_arbiter_i8_if.sv
// Handshake bundle for sub_arbiter_i8: two requester channels and two response channels.
//   req0/req1 : valid/ready handshake carrying minuend a and subtrahend b
//   rsp0/rsp1 : valid/ready handshake carrying result y
// The master modport is the requester side, the slave modport is the arbiter side.
interface sub_arbiter_i8_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_y;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_y;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp0_y, rsp1_valid, rsp1_y
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp0_y, rsp1_valid, rsp1_y
    );
endinterface

// File: rtl/sub_arbiter_i8.sv
// Two-requester round-robin arbiter in front of one shared subtractor (y = a - b, wrapping).
// Ports:
//   clock    : rising-edge clock
//   reset    : synchronous active-low reset
//   bus      : sub_arbiter_i8_if slave (request and response handshakes)
//   busy     : high whenever an operation is in flight (state not IDLE)
//   op_count : completed operations, saturating at 0xFFFF
module sub_arbiter_i8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    sub_arbiter_i8_if.slave      bus,
    output logic                 busy,
    output logic [15:0]          op_count
);
    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             gnt_q, gnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [15:0]      cnt_q, cnt_d;

    logic any_valid;
    logic pick;
    logic rsp_fire;
    logic rdy0, rdy1;

    assign any_valid = bus.req0_valid | bus.req1_valid;
    // Pointer only matters on contention; a lone valid always wins.
    assign pick      = (bus.req0_valid & bus.req1_valid) ? ptr_q : bus.req1_valid;
    // Only the granted requester's response ready is observed.
    assign rsp_fire  = gnt_q ? bus.rsp1_ready : bus.rsp0_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        rdy0    = 1'b0;
        rdy1    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    rdy0    = ~pick;
                    rdy1    = pick;
                    gnt_d   = pick;
                    a_d     = pick ? bus.req1_a : bus.req0_a;
                    b_d     = pick ? bus.req1_b : bus.req0_b;
                    state_d = StExec;
                end
            end
            StExec: begin
                y_d     = a_q - b_q;
                state_d = StDone;
            end
            StDone: begin
                if (rsp_fire) begin
                    state_d = StIdle;
                    ptr_d   = ~gnt_q;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    // A request is never acknowledged while reset is held low.
    assign bus.req0_ready = rdy0 & reset;
    assign bus.req1_ready = rdy1 & reset;
    assign bus.rsp0_valid = (state_q == StDone) & ~gnt_q;
    assign bus.rsp1_valid = (state_q == StDone) & gnt_q;
    assign bus.rsp0_y     = y_q;
    assign bus.rsp1_y     = y_q;
    assign busy           = (state_q != StIdle);
    assign op_count       = cnt_q;
endmodule
